// File: rtl/i2c_cmd_sequencer.sv
// rtl/i2c_cmd_sequencer.sv - request FIFO and command sequencer in front of i2c_master
// Turns whole read/write transactions into ADDR/DATA/WRITE|READ pulses and returns one response each.
module i2c_cmd_sequencer #(
  parameter int DEPTH      = 4,
  parameter int PTR_W      = 2,
  parameter int START_WAIT = 15,
  parameter int TIMEOUT    = 1023
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_rw,
  input  logic [6:0]       req_addr,
  input  logic [7:0]       req_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_rw,
  output logic [7:0]       rsp_data,
  output logic             rsp_err,
  output logic [PTR_W:0]   fifo_count,
  output logic [2:0]       m_cmd,
  output logic [7:0]       m_inp,
  input  logic [7:0]       m_out,
  input  logic             m_stat
);

  localparam int TW = (TIMEOUT > START_WAIT) ? $clog2(TIMEOUT + 1) : $clog2(START_WAIT + 1);
  localparam logic [TW-1:0]  SW_LAST = TW'(START_WAIT);
  localparam logic [TW-1:0]  TO_LAST = TW'(TIMEOUT);
  localparam logic [PTR_W:0] FULL    = (PTR_W+1)'(DEPTH);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_ADDR       = 3'd1;
  localparam logic [2:0] S_DATA       = 3'd2;
  localparam logic [2:0] S_GO         = 3'd3;
  localparam logic [2:0] S_WAIT_START = 3'd4;
  localparam logic [2:0] S_WAIT_DONE  = 3'd5;
  localparam logic [2:0] S_RESP       = 3'd6;

  localparam logic [2:0] CMD_NONE  = 3'd0;
  localparam logic [2:0] CMD_ADDR  = 3'd1;
  localparam logic [2:0] CMD_DATA  = 3'd2;
  localparam logic [2:0] CMD_READ  = 3'd3;
  localparam logic [2:0] CMD_WRITE = 3'd4;

  logic             fifo_rw   [DEPTH];
  logic [6:0]       fifo_addr [DEPTH];
  logic [7:0]       fifo_data [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;

  logic [2:0]    state;
  logic [TW-1:0] timer;
  logic          cur_rw;
  logic [7:0]    cur_data;

  logic push, pop;

  assign req_ready  = (count != FULL);
  assign fifo_count = count;
  assign push       = req_valid && req_ready;
  // A pending response blocks the next start unless it is consumed on this very edge.
  assign pop        = (state == S_IDLE) && (count != '0) && (!rsp_valid || rsp_ready);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rw[wr_ptr]   <= req_rw;
      fifo_addr[wr_ptr] <= req_addr;
      fifo_data[wr_ptr] <= req_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // m_cmd is loaded on entry to ADDR/DATA/GO, so each command is visible for exactly the cycle the FSM sits there.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      timer     <= '0;
      cur_rw    <= 1'b0;
      cur_data  <= 8'h00;
      m_cmd     <= CMD_NONE;
      m_inp     <= 8'h00;
      rsp_valid <= 1'b0;
      rsp_rw    <= 1'b0;
      rsp_data  <= 8'h00;
      rsp_err   <= 1'b0;
    end else begin
      m_cmd <= CMD_NONE;
      if (rsp_valid && rsp_ready) rsp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pop) begin
            cur_rw   <= fifo_rw[rd_ptr];
            cur_data <= fifo_data[rd_ptr];
            m_cmd    <= CMD_ADDR;
            m_inp    <= {1'b0, fifo_addr[rd_ptr]};
            state    <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (cur_rw) begin
            m_cmd <= CMD_READ;
            state <= S_GO;
          end else begin
            m_cmd <= CMD_DATA;
            m_inp <= cur_data;
            state <= S_DATA;
          end
        end
        S_DATA: begin
          m_cmd <= CMD_WRITE;
          state <= S_GO;
        end
        S_GO: begin
          timer <= '0;
          state <= S_WAIT_START;
        end
        S_WAIT_START: begin
          if (m_stat) begin
            timer <= '0;
            state <= S_WAIT_DONE;
          end else if (timer == SW_LAST) begin
            rsp_valid <= 1'b1;
            rsp_rw    <= cur_rw;
            rsp_data  <= 8'h00;
            rsp_err   <= 1'b1;
            state     <= S_RESP;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_WAIT_DONE: begin
          if (!m_stat) begin
            rsp_valid <= 1'b1;
            rsp_rw    <= cur_rw;
            rsp_data  <= cur_rw ? m_out : 8'h00;
            rsp_err   <= 1'b0;
            state     <= S_RESP;
          end else if (timer == TO_LAST) begin
            rsp_valid <= 1'b1;
            rsp_rw    <= cur_rw;
            rsp_data  <= 8'h00;
            rsp_err   <= 1'b1;
            state     <= S_RESP;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// tb/tb_i2c_cmd_sequencer.sv - self-checking bench for i2c_cmd_sequencer
// Transaction-level model of commands, FIFO occupancy and responses, plus directed latency checks.
module tb_i2c_cmd_sequencer;

  localparam int DEPTH      = 4;
  localparam int PTR_W      = 2;
  localparam int START_WAIT = 15;
  localparam int TIMEOUT    = 1023;
  localparam int M_NORMAL   = 0;
  localparam int M_NEVER    = 1;
  localparam int M_STUCK    = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           req_valid = 1'b0;
  logic           req_ready;
  logic           req_rw = 1'b0;
  logic [6:0]     req_addr = 7'h00;
  logic [7:0]     req_data = 8'h00;
  logic           rsp_valid;
  logic           rsp_ready = 1'b1;
  logic           rsp_rw;
  logic [7:0]     rsp_data;
  logic           rsp_err;
  logic [PTR_W:0] fifo_count;
  logic [2:0]     m_cmd;
  logic [7:0]     m_inp;
  logic [7:0]     m_out = 8'h00;
  logic           m_stat = 1'b0;

  i2c_cmd_sequencer #(
    .DEPTH(DEPTH), .PTR_W(PTR_W), .START_WAIT(START_WAIT), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
    .req_addr(req_addr), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rw(rsp_rw),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .fifo_count(fifo_count),
    .m_cmd(m_cmd), .m_inp(m_inp), .m_out(m_out), .m_stat(m_stat)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [2:0] cmd; logic [7:0] inp; } cmd_t;
  typedef struct packed { logic rw; logic [7:0] data; logic err; } rsp_t;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  int         mode = M_NORMAL;
  int         m_delay = 2;
  int         m_hold = 20;
  logic [7:0] m_rdata = 8'h00;

  cmd_t       exp_cmd[$];
  rsp_t       exp_rsp[$];
  int         mcount = 0;
  bit         busy = 0, pend_push = 0, pend_hs = 0, expect_next = 0, prev_rv = 0;
  logic       p_rw;
  logic [6:0] p_addr;
  logic [7:0] p_data;
  logic [7:0] last_inp = 8'h00;
  rsp_t       prev_pl;
  int         last_push_edge = 0, go_cyc = 0, nrise = 0, rsp_count = 0;
  int         cmd_cyc[8];
  logic [7:0] cmd_inp[8];
  int         rise_delta[64];
  rsp_t       rsp_hist[64];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Master model: raise m_stat m_delay cycles after WRITE/READ, hold m_hold cycles, present m_rdata on release.
  initial begin : master
    int phase, cnt;
    phase = 0;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_stat = 1'b0;
        phase = 0;
      end else if (phase == 0) begin
        if ((m_cmd == 3'd3 || m_cmd == 3'd4) && mode != M_NEVER) begin
          phase = 1;
          cnt = m_delay;
        end
      end else if (phase == 1) begin
        cnt--;
        if (cnt <= 0) begin
          m_stat = 1'b1;
          phase = 2;
          cnt = m_hold;
        end
      end else begin
        if (mode == M_STUCK) cnt = 1;
        else begin
          cnt--;
          if (cnt <= 0) begin
            m_stat = 1'b0;
            m_out = m_rdata;
            phase = 0;
          end
        end
      end
    end
  end

  // Compare process: model state reflects every edge so far; effects of the coming edge are noted as pending.
  initial begin : compare
    cmd_t c;
    rsp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_cmd.delete();
        exp_rsp.delete();
        mcount = 0; busy = 0; pend_push = 0; pend_hs = 0;
        expect_next = 0; prev_rv = 0; last_inp = 8'h00;
        chk("rst_m_cmd", m_cmd, 0);
        chk("rst_m_inp", m_inp, 0);
        chk("rst_rsp", {rsp_valid, rsp_rw, rsp_data, rsp_err}, 0);
        chk("rst_fifo_count", fifo_count, 0);
      end else begin
        if (pend_push) begin
          mcount++;
          c.cmd = 3'd1; c.inp = {1'b0, p_addr}; exp_cmd.push_back(c);
          if (p_rw) begin
            c.cmd = 3'd3; c.inp = {1'b0, p_addr}; exp_cmd.push_back(c);
          end else begin
            c.cmd = 3'd2; c.inp = p_data; exp_cmd.push_back(c);
            c.cmd = 3'd4; c.inp = p_data; exp_cmd.push_back(c);
          end
        end
        if (pend_hs) busy = 0;
        if (expect_next) chk("cmd_consecutive", m_cmd != 3'd0, 1);
        if (m_cmd != 3'd0) begin
          if (exp_cmd.size() == 0) begin
            checks++; failures++;
            $display("FAIL cmd_unexpected actual=%0d required=none", m_cmd);
          end else begin
            chk("cmd_stream", {m_cmd, m_inp}, exp_cmd[0]);
            void'(exp_cmd.pop_front());
          end
          cmd_cyc[m_cmd] = cyc;
          cmd_inp[m_cmd] = m_inp;
          if (m_cmd == 3'd1) begin
            chk("start_when_free", busy, 0);
            chk("start_nonempty", mcount > 0, 1);
            busy = 1;
            mcount--;
          end
          if (m_cmd == 3'd3 || m_cmd == 3'd4) begin
            go_cyc = cyc;
            e.rw = (m_cmd == 3'd3);
            e.err = (mode != M_NORMAL);
            e.data = (e.rw && mode == M_NORMAL) ? m_rdata : 8'h00;
            exp_rsp.push_back(e);
          end
          last_inp = m_inp;
        end else begin
          chk("m_inp_hold", m_inp, last_inp);
        end
        expect_next = (m_cmd == 3'd1 || m_cmd == 3'd2);
        chk("fifo_count", fifo_count, mcount);
        chk("req_ready", req_ready, mcount != DEPTH);
        if (prev_rv && !pend_hs)
          chk("rsp_hold", {rsp_valid, rsp_rw, rsp_data, rsp_err}, {1'b1, prev_pl});
        if (rsp_valid && !prev_rv && nrise < 64) begin
          rise_delta[nrise] = cyc - go_cyc;
          nrise++;
        end
        pend_push = req_valid && req_ready;
        if (pend_push) begin
          p_rw = req_rw; p_addr = req_addr; p_data = req_data;
          last_push_edge = cyc + 1;
        end
        pend_hs = rsp_valid && rsp_ready;
        if (pend_hs) begin
          if (exp_rsp.size() == 0) begin
            checks++; failures++;
            $display("FAIL rsp_unexpected actual=0x%0h required=none", {rsp_rw, rsp_data, rsp_err});
          end else begin
            chk("rsp_payload", {rsp_rw, rsp_data, rsp_err}, exp_rsp[0]);
            void'(exp_rsp.pop_front());
          end
          if (rsp_count < 64) rsp_hist[rsp_count] = {rsp_rw, rsp_data, rsp_err};
          rsp_count++;
        end
        prev_rv = rsp_valid;
        prev_pl = {rsp_rw, rsp_data, rsp_err};
      end
    end
  end

  task automatic send(input logic rw, input logic [6:0] a, input logic [7:0] d,
                      input int budget, output bit ok);
    req_rw = rw; req_addr = a; req_data = d; req_valid = 1'b1; ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (req_ready) begin
        ok = 1;
        break;
      end
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int n, input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      if (rsp_count >= n) break;
      @(posedge clk); #1;
    end
    checks++;
    if (rsp_count < n) begin
      failures++;
      $display("FAIL %s responses actual=%0d required=%0d", name, rsp_count, n);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Write 0x77/0xAB, m_stat 2 cycles after WRITE for 20 cycles: rsp visible 2+1+20 cycles after WRITE.
  task automatic run_write(input string tag);
    bit ok;
    int base, rb, pe;
    mode = M_NORMAL; m_delay = 2; m_hold = 20;
    base = rsp_count; rb = nrise;
    send(1'b0, 7'h77, 8'hAB, 8, ok);
    chk({tag, "_accept"}, ok, 1);
    pe = last_push_edge;
    wait_rsp(base + 1, 100, {tag, "_rsp_wait"});
    chk({tag, "_addr_latency"}, cmd_cyc[1] - pe, 1);
    chk({tag, "_data_after_addr"}, cmd_cyc[2] - cmd_cyc[1], 1);
    chk({tag, "_write_after_addr"}, cmd_cyc[4] - cmd_cyc[1], 2);
    chk({tag, "_addr_inp"}, cmd_inp[1], 8'h77);
    chk({tag, "_data_inp"}, cmd_inp[2], 8'hAB);
    chk({tag, "_rsp"}, rsp_hist[base], {1'b0, 8'h00, 1'b0});
    chk({tag, "_rsp_delay"}, rise_delta[rb], 23);
    idle(3);
  endtask

  initial begin : main
    bit ok;
    int base, rb, acc, nr;
    for (int i = 0; i < 8; i++) begin
      cmd_cyc[i] = 0;
      cmd_inp[i] = 8'h00;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    idle(2);

    run_write("s1");

    // Read 0x77, m_stat from WRITE+2 for 5 cycles, 0x5A returned.
    mode = M_NORMAL; m_delay = 2; m_hold = 5; m_rdata = 8'h5A;
    base = rsp_count; rb = nrise;
    send(1'b1, 7'h77, 8'h00, 8, ok);
    wait_rsp(base + 1, 100, "s2_rsp_wait");
    chk("s2_read_after_addr", cmd_cyc[3] - cmd_cyc[1], 1);
    chk("s2_read_inp", cmd_inp[3], 8'h77);
    chk("s2_rsp", rsp_hist[base], {1'b1, 8'h5A, 1'b0});
    chk("s2_rsp_delay", rise_delta[rb], 8);
    idle(3);

    // Back-pressure: one in flight plus DEPTH queued, sixth refused.
    mode = M_NORMAL; m_delay = 1; m_hold = 3; m_rdata = 8'hC3;
    rsp_ready = 1'b0;
    base = rsp_count; acc = 0;
    for (int i = 0; i < 6; i++) begin
      send((i == 1 || i == 3), 7'h10 + 7'(i), 8'h01 + 8'(i), (i < 5) ? 8 : 20, ok);
      acc += ok;
    end
    chk("s3_accepted", acc, 5);
    chk("s3_req_ready_full", req_ready, 0);
    chk("s3_fifo_full", fifo_count, 4);
    rsp_ready = 1'b1;
    wait_rsp(base + 5, 400, "s3_rsp_wait");
    idle(2);
    chk("s3_fifo_drained", fifo_count, 0);
    chk("s3_rsp1_read", rsp_hist[base + 1], {1'b1, 8'hC3, 1'b0});
    chk("s3_rsp4_write", rsp_hist[base + 4], {1'b0, 8'h00, 1'b0});
    idle(3);

    // Start timeout: m_stat never rises.
    mode = M_NEVER;
    base = rsp_count; rb = nrise;
    send(1'b0, 7'h20, 8'h11, 8, ok);
    send(1'b0, 7'h21, 8'h22, 8, ok);
    wait_rsp(base + 2, 100, "s4_rsp_wait");
    chk("s4_rsp0_delay", rise_delta[rb], START_WAIT + 2);
    chk("s4_rsp1_delay", rise_delta[rb + 1], START_WAIT + 2);
    chk("s4_rsp0", rsp_hist[base], {1'b0, 8'h00, 1'b1});
    chk("s4_rsp1", rsp_hist[base + 1], {1'b0, 8'h00, 1'b1});
    chk("s4_second_addr", cmd_inp[1], 8'h21);
    idle(3);

    // Completion timeout: m_stat stuck high from WRITE+2; WAIT_DONE spans TIMEOUT+1 cycles.
    mode = M_STUCK; m_delay = 2;
    base = rsp_count; rb = nrise;
    send(1'b0, 7'h30, 8'h44, 8, ok);
    wait_rsp(base + 1, 1300, "s5_rsp_wait");
    chk("s5_rsp_delay", rise_delta[rb], TIMEOUT + 4);
    chk("s5_rsp", rsp_hist[base], {1'b0, 8'h00, 1'b1});
    m_rdata = 8'h66; m_hold = 3; mode = M_NORMAL;
    idle(3);
    base = rsp_count;
    send(1'b1, 7'h31, 8'h00, 8, ok);
    wait_rsp(base + 1, 100, "s5_after_rsp_wait");
    chk("s5_after_rsp", rsp_hist[base], {1'b1, 8'h66, 1'b0});
    idle(3);

    // Reset in WAIT_DONE with two queued entries.
    mode = M_NORMAL; m_delay = 2; m_hold = 60;
    send(1'b0, 7'h40, 8'h01, 8, ok);
    send(1'b0, 7'h41, 8'h02, 8, ok);
    send(1'b0, 7'h42, 8'h03, 8, ok);
    ok = 0;
    for (int i = 0; i < 30; i++) begin
      if (m_stat) begin
        ok = 1;
        break;
      end
      @(posedge clk); #1;
    end
    chk("s6_busy_seen", ok, 1);
    idle(3);
    chk("s6_queued", fifo_count, 2);
    base = rsp_count; nr = nrise;
    rst = 1'b1;
    #1;
    chk("s6_rst_m_cmd", m_cmd, 0);
    chk("s6_rst_rsp_valid", rsp_valid, 0);
    chk("s6_rst_fifo_count", fifo_count, 0);
    idle(2);
    rst = 1'b0;
    idle(80);
    chk("s6_no_rsp", rsp_count, base);
    chk("s6_no_rsp_valid", nrise, nr);
    run_write("s6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
